// File: rtl/pool_sched_if.sv
// Bus between the pool sequencer and its surroundings: start/hold control,
// status, dual-port RAM read side and the 2x2 max-pool engine side.
interface pool_sched_if #(
  parameter int data_width = 16,
  parameter int addr_width = 12
);
  logic                  start;
  logic                  hold;
  logic                  busy;
  logic                  done;
  logic                  rd_en;
  logic [addr_width-1:0] rd_addr_a;
  logic [addr_width-1:0] rd_addr_b;
  logic [data_width-1:0] ram_dout_a;
  logic [data_width-1:0] ram_dout_b;
  logic [data_width-1:0] pool_d_in1;
  logic [data_width-1:0] pool_d_in2;
  logic                  pool_in_valid;
  logic                  pool_out_valid;
  logic [7:0]            ch_idx;
  logic [15:0]           out_cnt;

  // Sequencer side
  modport master (
    input  start, hold, ram_dout_a, ram_dout_b, pool_out_valid,
    output busy, done, rd_en, rd_addr_a, rd_addr_b,
           pool_d_in1, pool_d_in2, pool_in_valid, ch_idx, out_cnt
  );

  // Environment side: controller, buffer RAM and pool engine
  modport slave (
    output start, hold, ram_dout_a, ram_dout_b, pool_out_valid,
    input  busy, done, rd_en, rd_addr_a, rd_addr_b,
           pool_d_in1, pool_d_in2, pool_in_valid, ch_idx, out_cnt
  );
endinterface

// File: rtl/pool_sched.sv
// Streams a stored feature map (channel, row pair, column order) out of a
// dual-read-port RAM into the 2x2 max-pool engine, one column of a row pair
// per cycle. Addresses come from incrementing registers, in_valid is aligned
// to the one-cycle RAM latency, and completion waits for the last pool result.
module pool_sched #(
  parameter int data_width = 16,
  parameter int addr_width = 12,
  parameter int img_h      = 24,
  parameter int img_w      = 24,
  parameter int ch_num     = 6
) (
  input logic         clk,
  input logic         rst_n,
  pool_sched_if.master bus
);

  localparam int TOTAL = ch_num * img_h * img_w / 4;

  localparam logic [15:0]           total_cnt = 16'(TOTAL);
  localparam logic [15:0]           total_m1  = 16'(TOTAL - 1);
  localparam logic [15:0]           x_last    = 16'(img_w - 1);
  localparam logic [15:0]           p_last    = 16'(img_h / 2 - 1);
  localparam logic [7:0]            ch_last   = 8'(ch_num - 1);
  localparam logic [addr_width-1:0] row_step  = addr_width'(img_w);
  // end of a row pair: step past the odd row as well as to the next column
  localparam logic [addr_width-1:0] wrap_step = addr_width'(img_w + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state;
  logic                  busy_q;
  logic                  done_q;
  logic [addr_width-1:0] addr_a;
  logic [addr_width-1:0] addr_b;
  logic [15:0]           x_cnt;
  logic [15:0]           p_cnt;
  logic [7:0]            ch_q;
  logic [15:0]           out_cnt_q;

  logic                  rd_p0;
  logic                  last_rd;
  logic                  cnt_inc;
  logic                  hit_total;
  logic                  vld_p1;
  logic [data_width-1:0] pix_a_p1;
  logic [data_width-1:0] pix_b_p1;

  // hold gates the read in the same cycle it is raised
  assign rd_p0     = (state == S_RUN) && !bus.hold;
  assign last_rd   = rd_p0 && (ch_q == ch_last) && (p_cnt == p_last) && (x_cnt == x_last);
  assign cnt_inc   = bus.pool_out_valid && busy_q && (out_cnt_q != total_cnt);
  assign hit_total = (out_cnt_q == total_cnt) || (cnt_inc && (out_cnt_q == total_m1));

  // Pass control: state, scan counters, address registers and result count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      addr_a    <= '0;
      addr_b    <= '0;
      x_cnt     <= '0;
      p_cnt     <= '0;
      ch_q      <= '0;
      out_cnt_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cnt_inc) out_cnt_q <= out_cnt_q + 16'd1;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state     <= S_RUN;
            busy_q    <= 1'b1;
            addr_a    <= '0;
            addr_b    <= row_step;
            x_cnt     <= '0;
            p_cnt     <= '0;
            ch_q      <= '0;
            out_cnt_q <= '0;
          end
        end
        S_RUN: begin
          if (last_rd) begin
            // scan registers stay on the final pixel for observation
            state <= S_DRAIN;
          end else if (rd_p0) begin
            if (x_cnt == x_last) begin
              x_cnt  <= '0;
              addr_a <= addr_a + wrap_step;
              addr_b <= addr_b + wrap_step;
              if (p_cnt == p_last) begin
                p_cnt <= '0;
                ch_q  <= ch_q + 8'd1;
              end else begin
                p_cnt <= p_cnt + 16'd1;
              end
            end else begin
              x_cnt  <= x_cnt + 16'd1;
              addr_a <= addr_a + 1'b1;
              addr_b <= addr_b + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (hit_total) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: RAM read latency, valid follows the issued read by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= rd_p0;
  end

  assign pix_a_p1 = bus.ram_dout_a;
  assign pix_b_p1 = bus.ram_dout_b;

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.rd_en         = rd_p0;
  assign bus.rd_addr_a     = addr_a;
  assign bus.rd_addr_b     = addr_b;
  assign bus.pool_d_in1    = pix_a_p1;
  assign bus.pool_d_in2    = pix_b_p1;
  assign bus.pool_in_valid = vld_p1;
  assign bus.ch_idx        = ch_q;
  assign bus.out_cnt       = out_cnt_q;

endmodule

// File: tb/tb_pool_sched.sv
// Bench for pool_sched: a small 4x4x2 instance for directed timing, stall,
// start-while-busy and reset cases, and a default 24x24x6 instance with random
// data and random hold. Each instance has a RAM model, a behavioural pool
// engine and a monitor comparing against addresses/results derived directly
// from the memory layout.
module tb_pool_sched;
  localparam int NENV = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rstn_d  [NENV];
  logic start_d [NENV];
  logic hold_d  [NENV];
  logic extra_d [NENV];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < NENV; g++) begin : env
    localparam int H    = (g == 0) ? 4 : 24;
    localparam int W    = (g == 0) ? 4 : 24;
    localparam int C    = (g == 0) ? 2 : 6;
    localparam int NPIX = C * H * W;
    localparam int TOT  = NPIX / 4;

    pool_sched_if #(.data_width(16), .addr_width(12)) bus ();

    pool_sched #(
      .data_width(16), .addr_width(12), .img_h(H), .img_w(W), .ch_num(C)
    ) dut (
      .clk  (clk),
      .rst_n(rstn_d[g]),
      .bus  (bus.master)
    );

    logic [15:0] mem [4096];
    logic [15:0] ram_a, ram_b;
    logic        half;
    logic [15:0] col_q;
    logic [15:0] pd [3];
    logic        pv [3];
    logic        rd_prev;
    logic [15:0] last_val;
    int          rd_count, res_count, done_count, last_res_cyc;

    initial begin
      for (int i = 0; i < 4096; i++)
        mem[12'(i)] = (i < NPIX) ? ((g == 0) ? 16'(i) : 16'($urandom)) : 16'(0);
    end

    function automatic logic [15:0] mx(input logic [15:0] a, input logic [15:0] b);
      return (a > b) ? a : b;
    endfunction

    // k-th read of a pass: channel, row pair, column straight from the layout
    function automatic int exp_a(input int k);
      int per, c, r;
      per = H * W / 2;
      c = k / per;
      r = k % per;
      return c * H * W + 2 * (r / W) * W + (r % W);
    endfunction

    // k-th pool result: max of the 2x2 window it covers
    function automatic logic [15:0] exp_res(input int k);
      int per, c, r, base;
      per  = H * W / 4;
      c    = k / per;
      r    = k % per;
      base = c * H * W + 2 * (r / (W / 2)) * W + 2 * (r % (W / 2));
      return mx(mx(mem[12'(base)], mem[12'(base + 1)]),
                mx(mem[12'(base + W)], mem[12'(base + W + 1)]));
    endfunction

    assign bus.start = start_d[g];
    assign bus.hold  = hold_d[g];

    // buffer RAM, one-cycle read latency on both ports
    always @(posedge clk) begin
      if (bus.rd_en) begin
        ram_a <= mem[bus.rd_addr_a];
        ram_b <= mem[bus.rd_addr_b];
      end
    end
    assign bus.ram_dout_a = ram_a;
    assign bus.ram_dout_b = ram_b;

    // pool engine: pairs consecutive columns, result 3 cycles after the second
    always @(posedge clk or negedge rstn_d[g]) begin
      if (!rstn_d[g]) begin
        half  <= 1'b0;
        pv[0] <= 1'b0;
        pv[1] <= 1'b0;
        pv[2] <= 1'b0;
      end else begin
        pv[0] <= 1'b0;
        if (bus.pool_in_valid) begin
          if (!half) col_q <= mx(bus.pool_d_in1, bus.pool_d_in2);
          else begin
            pv[0] <= 1'b1;
            pd[0] <= mx(col_q, mx(bus.pool_d_in1, bus.pool_d_in2));
          end
          half <= !half;
        end
        pv[1] <= pv[0];
        pd[1] <= pd[0];
        pv[2] <= pv[1];
        pd[2] <= pd[1];
      end
    end
    assign bus.pool_out_valid = pv[2] | extra_d[g];

    // monitor: read addresses, in_valid alignment, result values, done count
    always @(negedge clk) begin
      if (!rstn_d[g]) begin
        rd_count   <= 0;
        res_count  <= 0;
        done_count <= 0;
        rd_prev    <= 1'b0;
      end else if (bus.start && !bus.busy) begin
        rd_count   <= 0;
        res_count  <= 0;
        done_count <= 0;
        rd_prev    <= bus.rd_en;
      end else begin
        rd_prev <= bus.rd_en;
        chk($sformatf("e%0d_in_valid_lat", g), 64'(bus.pool_in_valid), 64'(rd_prev));
        if (bus.rd_en) begin
          chk($sformatf("e%0d_rd_addr_a[%0d]", g, rd_count), 64'(bus.rd_addr_a), 64'(exp_a(rd_count)));
          chk($sformatf("e%0d_rd_addr_b[%0d]", g, rd_count), 64'(bus.rd_addr_b), 64'(exp_a(rd_count) + W));
          rd_count <= rd_count + 1;
        end
        if (pv[2]) begin
          chk($sformatf("e%0d_result[%0d]", g, res_count), 64'(pd[2]), 64'(exp_res(res_count)));
          last_val  <= pd[2];
          res_count <= res_count + 1;
          if (res_count == TOT - 1) last_res_cyc <= cyc;
        end
        if (bus.done) done_count <= done_count + 1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done0(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (env[0].bus.done === 1'b1) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic wait_done1(input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (env[1].bus.done === 1'b1) begin
        at = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic chk_reset0(input string pfx);
    chk({pfx, "_busy"},          64'(env[0].bus.busy),          64'(0));
    chk({pfx, "_done"},          64'(env[0].bus.done),          64'(0));
    chk({pfx, "_rd_en"},         64'(env[0].bus.rd_en),         64'(0));
    chk({pfx, "_pool_in_valid"}, 64'(env[0].bus.pool_in_valid), 64'(0));
    chk({pfx, "_rd_addr_a"},     64'(env[0].bus.rd_addr_a),     64'(0));
    chk({pfx, "_rd_addr_b"},     64'(env[0].bus.rd_addr_b),     64'(0));
    chk({pfx, "_ch_idx"},        64'(env[0].bus.ch_idx),        64'(0));
    chk({pfx, "_out_cnt"},       64'(env[0].bus.out_cnt),       64'(0));
  endtask

  initial begin
    int t0, at;
    for (int i = 0; i < NENV; i++) begin
      rstn_d[i]  = 1'b0;
      start_d[i] = 1'b0;
      hold_d[i]  = 1'b0;
      extra_d[i] = 1'b0;
    end
    repeat (3) step();
    chk_reset0("por");
    for (int i = 0; i < NENV; i++) rstn_d[i] = 1'b1;
    repeat (2) step();

    // basic pass and latency, 4x4x2, pixel value = address
    start_d[0] = 1'b1;
    t0 = cyc;
    step();
    start_d[0] = 1'b0;
    chk("basic_busy_t1",  64'(env[0].bus.busy),          64'(1));
    chk("basic_rd_en_t1", 64'(env[0].bus.rd_en),         64'(1));
    chk("basic_addr_a0",  64'(env[0].bus.rd_addr_a),     64'(0));
    chk("basic_addr_b0",  64'(env[0].bus.rd_addr_b),     64'(4));
    chk("basic_inv_t1",   64'(env[0].bus.pool_in_valid), 64'(0));
    step();
    chk("basic_inv_t2",   64'(env[0].bus.pool_in_valid), 64'(1));
    wait_done0(100, at);
    chk("basic_done_seen",  64'(at >= 0), 64'(1));
    chk("basic_done_time",  64'(at - t0), 64'(21));
    chk("basic_done_after", 64'(at - env[0].last_res_cyc), 64'(1));
    chk("basic_busy_done",  64'(env[0].bus.busy), 64'(1));
    step();
    chk("basic_busy_after", 64'(env[0].bus.busy),    64'(0));
    chk("basic_reads",      64'(env[0].rd_count),    64'(16));
    chk("basic_results",    64'(env[0].res_count),   64'(8));
    chk("basic_out_cnt",    64'(env[0].bus.out_cnt), 64'(8));
    chk("basic_last_val",   64'(env[0].last_val),    64'(31));
    chk("basic_done_cnt",   64'(env[0].done_count),  64'(1));

    // stall: 3 cycles after the 5th read, 1 more later, then hold through drain
    step();
    start_d[0] = 1'b1;
    t0 = cyc;
    step();
    start_d[0] = 1'b0;
    for (int i = 0; i < 20 && env[0].rd_count < 5; i++) step();
    hold_d[0] = 1'b1;
    #1;
    chk("stall_rd_en_off", 64'(env[0].bus.rd_en), 64'(0));
    repeat (3) step();
    hold_d[0] = 1'b0;
    for (int i = 0; i < 20 && env[0].rd_count < 10; i++) step();
    hold_d[0] = 1'b1;
    #1;
    chk("stall_rd_en_off2", 64'(env[0].bus.rd_en), 64'(0));
    step();
    hold_d[0] = 1'b0;
    for (int i = 0; i < 20 && env[0].rd_count < 16; i++) step();
    hold_d[0] = 1'b1;
    wait_done0(100, at);
    hold_d[0] = 1'b0;
    chk("stall_done_seen", 64'(at >= 0), 64'(1));
    chk("stall_done_time", 64'(at - t0), 64'(25));
    step();
    chk("stall_reads",    64'(env[0].rd_count),    64'(16));
    chk("stall_results",  64'(env[0].res_count),   64'(8));
    chk("stall_out_cnt",  64'(env[0].bus.out_cnt), 64'(8));

    // start mid-run and coincident with done; extra strobes at done and idle
    step();
    start_d[0] = 1'b1;
    t0 = cyc;
    step();
    start_d[0] = 1'b0;
    repeat (5) step();
    start_d[0] = 1'b1;
    step();
    start_d[0] = 1'b0;
    wait_done0(100, at);
    start_d[0] = 1'b1;
    extra_d[0] = 1'b1;
    chk("sb_done_time", 64'(at - t0), 64'(21));
    step();
    start_d[0] = 1'b0;
    chk("sb_busy_after_done", 64'(env[0].bus.busy),  64'(0));
    chk("sb_rd_en_after",     64'(env[0].bus.rd_en), 64'(0));
    repeat (2) step();
    extra_d[0] = 1'b0;
    repeat (30) step();
    chk("sb_done_cnt",   64'(env[0].done_count),  64'(1));
    chk("sb_reads",      64'(env[0].rd_count),    64'(16));
    chk("sb_busy_idle",  64'(env[0].bus.busy),    64'(0));
    chk("sb_out_cnt_sat", 64'(env[0].bus.out_cnt), 64'(8));

    // reset during channel 1, then a clean restart
    start_d[0] = 1'b1;
    step();
    start_d[0] = 1'b0;
    for (int i = 0; i < 40 && env[0].bus.ch_idx != 8'd1; i++) step();
    chk("rst_reached_ch1", 64'(env[0].bus.ch_idx), 64'(1));
    repeat (2) step();
    rstn_d[0] = 1'b0;
    #1;
    chk_reset0("midrst");
    step();
    rstn_d[0] = 1'b1;
    repeat (4) step();
    chk("rst_no_done", 64'(env[0].bus.done), 64'(0));
    chk("rst_no_busy", 64'(env[0].bus.busy), 64'(0));
    start_d[0] = 1'b1;
    t0 = cyc;
    step();
    start_d[0] = 1'b0;
    chk("rst_restart_a", 64'(env[0].bus.rd_addr_a), 64'(0));
    chk("rst_restart_b", 64'(env[0].bus.rd_addr_b), 64'(4));
    chk("rst_restart_rd", 64'(env[0].bus.rd_en),    64'(1));
    wait_done0(100, at);
    chk("rst_done_time", 64'(at - t0), 64'(21));
    step();
    chk("rst_results",  64'(env[0].res_count),  64'(8));
    chk("rst_done_cnt", 64'(env[0].done_count), 64'(1));

    // default 24x24x6 with random data, no hold
    start_d[1] = 1'b1;
    t0 = cyc;
    step();
    start_d[1] = 1'b0;
    wait_done1(2500, at);
    chk("dflt_done_seen",  64'(at >= 0), 64'(1));
    chk("dflt_done_time",  64'(at - t0), 64'(1733));
    chk("dflt_done_after", 64'(at - env[1].last_res_cyc), 64'(1));
    step();
    chk("dflt_out_cnt", 64'(env[1].bus.out_cnt), 64'(864));
    chk("dflt_results", 64'(env[1].res_count),   64'(864));
    chk("dflt_reads",   64'(env[1].rd_count),    64'(1728));

    // default size again with random hold
    step();
    start_d[1] = 1'b1;
    step();
    start_d[1] = 1'b0;
    at = -1;
    for (int i = 0; i < 8000; i++) begin
      if (env[1].bus.done === 1'b1) begin
        at = cyc;
        break;
      end
      hold_d[1] = ($urandom_range(0, 3) == 0);
      step();
    end
    hold_d[1] = 1'b0;
    chk("rhold_done_seen",  64'(at >= 0), 64'(1));
    chk("rhold_done_after", 64'(at - env[1].last_res_cyc), 64'(1));
    step();
    chk("rhold_out_cnt", 64'(env[1].bus.out_cnt), 64'(864));
    chk("rhold_results", 64'(env[1].res_count),   64'(864));
    chk("rhold_reads",   64'(env[1].rd_count),    64'(1728));
    chk("rhold_done_cnt", 64'(env[1].done_count), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
